// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-BCD converter and the 7-segment display path.
// Segment codes are active-high (bit0=a .. bit6=g); polarity is applied at the output.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Elaboration-time 10**n, used to check the digit count covers the input range.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder with a blank override.
// Shared with the single-digit HEX display path.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin_bcd_seg7_scan.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock) feeding a
// time-multiplexed 7-segment scanner with one-hot digit enables.
module bin_bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int W              = 4,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [W-1:0]          i_bin,
  output logic                  o_ready,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_bcd_valid,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + W;
  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

  if (pow10(DIGITS) <= (longint'(1) << W) - 1) begin : g_too_few_digits
    $error("DIGITS too small to display every W-bit value");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 1");
  end

  // ---------------- converter ----------------
  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic [BIT_W-1:0]  bit_cnt;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[W+4*d +: 4] >= 4'd5) sr_adj[W+4*d +: 4] = sr[W+4*d +: 4] + 4'd3;
    end
  end

  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_ready     <= 1'b1;
      o_bcd       <= '0;
      o_bcd_valid <= 1'b0;
      sr          <= '0;
      bit_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      o_bcd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            sr      <= {{BCD_W{1'b0}}, i_bin};
            bit_cnt <= '0;
            o_ready <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr      <= sr_shift;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(W - 1)) begin
            o_bcd       <= sr_shift[SR_W-1 -: BCD_W];
            o_bcd_valid <= 1'b1;
            o_ready     <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- scanner ----------------
  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [IDX_W-1:0]  idx_next;
  logic              scan_wrap;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  logic [3:0]        nibble_sel;
  logic [6:0]        seg_raw;
  logic [6:0]        seg_out;

  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    idx_next = dig_idx;
    if (scan_wrap) idx_next = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (o_bcd[4*k +: 4] == 4'd0);
      blank[k]   = BLANK_LZ && (k != 0) && upper_zero;
    end
  end

  assign nibble_sel = o_bcd[4*idx_next +: 4];

  bcd_to_seg7 u_bcd_to_seg7 (
    .nibble (nibble_sel),
    .blank  (blank[idx_next]),
    .seg    (seg_raw)
  );

  assign seg_out = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

  // Segment pattern and enable are registered from the same next index, so they switch together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      o_dig_en <= DIGITS'(1);
      o_seg    <= SEG_RESET;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      dig_idx  <= idx_next;
      o_dig_en <= DIGITS'(1) << idx_next;
      o_seg    <= seg_out;
    end
  end

endmodule
